// File: rtl/itof_issue_sched.sv
`default_nettype none
// ============================================================================
//  Module      : itof_issue_sched
//  Description : Round-robin issue scheduler sharing one fixed-latency
//                pipelined itof converter between N_REQ requesters. Tracks
//                requester IDs alongside the converter pipeline, buffers
//                results in an in-order show-ahead FIFO and uses credit-based
//                issue control so no converter result is ever dropped.
//                Optional macro ITOF_SCHED_PERF_EN adds perf_issued and
//                perf_stall counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module itof_issue_sched #(
    parameter int NSTAGE     = 2,
    parameter int N_REQ      = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [N_REQ-1:0]                            req_valid,
    input  logic [32*N_REQ-1:0]                         req_x,
    output logic [N_REQ-1:0]                            req_ready,
    output logic [31:0]                                 cv_x,
    input  logic [31:0]                                 cv_y,
    output logic                                        resp_valid,
    input  logic                                        resp_ready,
    output logic [31:0]                                 resp_y,
    output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] resp_id
`ifdef ITOF_SCHED_PERF_EN
    ,
    output logic [31:0]                                 perf_issued,
    output logic [31:0]                                 perf_stall
`endif
);

    localparam int c_IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int c_PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CW  = $clog2(FIFO_DEPTH + NSTAGE + 2) + 1;
    localparam logic [c_IDW-1:0] c_LAST_ID  = c_IDW'(N_REQ - 1);
    localparam logic [c_PW-1:0]  c_LAST_PTR = c_PW'(FIFO_DEPTH - 1);
    localparam logic [c_CW-1:0]  c_DEPTH    = c_CW'(FIFO_DEPTH);

    // Slot 0 is the issue slot paired with cv_x; slots 1..NSTAGE follow the
    // converter's internal registers, so slot NSTAGE lines up with cv_y.
    logic [NSTAGE:0]    r_tv;
    logic [c_IDW-1:0]   r_tid [0:NSTAGE];
    logic [c_IDW-1:0]   r_ptr;

    logic [31:0]        r_mem_y  [0:FIFO_DEPTH-1];
    logic [c_IDW-1:0]   r_mem_id [0:FIFO_DEPTH-1];
    logic [c_PW-1:0]    r_wptr;
    logic [c_PW-1:0]    r_rptr;
    logic [c_CW-1:0]    r_count;

    logic [c_CW-1:0]    w_inflight;
    logic               w_credit;
    logic               w_found;
    logic [c_IDW-1:0]   w_grant;
    logic               w_accept;
    logic [31:0]        w_sel_x;
    int                 w_idx;
    logic               w_push;
    logic               w_pop;

    // Credit: count of results already committed (in flight or buffered).
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i <= NSTAGE; i++) begin
            w_inflight = w_inflight + c_CW'(r_tv[i]);
        end
        w_credit = !rst && ((w_inflight + r_count) < c_DEPTH);
    end

    // Round-robin search for the first valid requester starting at r_ptr.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= N_REQ) begin
                w_idx = w_idx - N_REQ;
            end
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_grant = c_IDW'(w_idx);
            end
        end
    end

    // Grant decode and operand mux.
    always_comb begin
        w_accept  = w_found && w_credit;
        req_ready = '0;
        w_sel_x   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = w_accept && (w_grant == c_IDW'(i));
            if (w_grant == c_IDW'(i)) begin
                w_sel_x = req_x[32*i +: 32];
            end
        end
    end

    // Issue stage: drive the converter, advance tag pipeline and RR pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cv_x  <= '0;
            r_ptr <= '0;
            r_tv  <= '0;
            for (int i = 0; i <= NSTAGE; i++) begin
                r_tid[i] <= '0;
            end
        end else begin
            r_tv     <= {r_tv[NSTAGE-1:0], w_accept};
            r_tid[0] <= w_accept ? w_grant : '0;
            for (int i = 1; i <= NSTAGE; i++) begin
                r_tid[i] <= r_tid[i-1];
            end
            if (w_accept) begin
                cv_x  <= w_sel_x;
                r_ptr <= (w_grant == c_LAST_ID) ? '0 : (w_grant + c_IDW'(1));
            end
        end
    end

    assign w_push     = r_tv[NSTAGE];
    assign resp_valid = (r_count != '0);
    assign w_pop      = resp_valid && resp_ready;
    assign resp_y     = r_mem_y[r_rptr];
    assign resp_id    = r_mem_id[r_rptr];

    // Result FIFO: capture aligned results, pop on consumer handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_y[i]  <= '0;
                r_mem_id[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem_y[r_wptr]  <= cv_y;
                r_mem_id[r_wptr] <= r_tid[NSTAGE];
                r_wptr           <= (r_wptr == c_LAST_PTR) ? '0 : (r_wptr + c_PW'(1));
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == c_LAST_PTR) ? '0 : (r_rptr + c_PW'(1));
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A capture into a full FIFO without a simultaneous pop means credit failed.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_push && !w_pop && (r_count == c_DEPTH)));

`ifdef ITOF_SCHED_PERF_EN
    // Performance counters: accepted issues and credit-blocked cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (w_accept) begin
                perf_issued <= perf_issued + 32'd1;
            end
            if ((|req_valid) && !w_credit) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_itof_issue_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_itof_issue_sched
//  Description : Self-checking bench for itof_issue_sched with a behavioural
//                itof converter model and a queue-based reference scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_itof_issue_sched;

    localparam int NSTAGE = 2;
    localparam int N_REQ  = 2;
    localparam int DEPTH  = 4;
    localparam int IDW    = 1;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [N_REQ-1:0]      req_valid = '0;
    logic [32*N_REQ-1:0]   req_x = '0;
    logic [N_REQ-1:0]      req_ready;
    logic [31:0]           cv_x;
    logic [31:0]           cv_y;
    logic                  resp_valid;
    logic                  resp_ready = 1'b0;
    logic [31:0]           resp_y;
    logic [IDW-1:0]        resp_id;
`ifdef ITOF_SCHED_PERF_EN
    logic [31:0]           perf_issued;
    logic [31:0]           perf_stall;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    itof_issue_sched #(.NSTAGE(NSTAGE), .N_REQ(N_REQ), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_x      (req_x),
        .req_ready  (req_ready),
        .cv_x       (cv_x),
        .cv_y       (cv_y),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_y     (resp_y),
        .resp_id    (resp_id)
`ifdef ITOF_SCHED_PERF_EN
        ,
        .perf_issued(perf_issued),
        .perf_stall (perf_stall)
`endif
    );

    // Integer to IEEE-754 single, round to nearest even.
    function automatic logic [31:0] itof(input logic [31:0] x);
        logic        s;
        logic [31:0] mag, rem, half;
        logic [24:0] mant;
        int          e, sh;
        logic [7:0]  ex;
        if (x == 32'd0) return 32'd0;
        s   = x[31];
        mag = s ? (~x + 32'd1) : x;
        e   = 0;
        for (int b = 0; b < 32; b++) if (mag[b]) e = b;
        ex = 8'(127 + e);
        if (e <= 23) begin
            mant = 25'(mag << (23 - e));
        end else begin
            sh   = e - 23;
            mant = 25'(mag >> sh);
            rem  = mag & ((32'd1 << sh) - 32'd1);
            half = 32'd1 << (sh - 1);
            if (rem > half || (rem == half && mant[0])) mant = mant + 25'd1;
            if (mant[24]) begin
                mant = mant >> 1;
                ex   = ex + 8'd1;
            end
        end
        return {s, ex, mant[22:0]};
    endfunction

    // Attached converter: NSTAGE registers sampling cv_x.
    logic [31:0] cpipe [NSTAGE];
    always @(posedge clk) begin
        cpipe[0] <= itof(cv_x);
        for (int i = 1; i < NSTAGE; i++) cpipe[i] <= cpipe[i-1];
    end
    assign cv_y = cpipe[NSTAGE-1];

    // Reference model: items waiting for capture (with due edge) and buffered results.
    typedef struct {
        int          due;
        logic [31:0] y;
        int          id;
    } item_t;
    item_t inq[$];
    item_t fq[$];
    int    p = 0, ecnt = 0, m_issued = 0, m_stall = 0, e_grant;
    logic [N_REQ-1:0] e_ready;
    logic             e_rv;
    logic [31:0]      e_y;
    logic [IDW-1:0]   e_id;

    task automatic model_expect();
        bit allowed;
        allowed = (inq.size() + fq.size()) < DEPTH;
        e_ready = '0;
        e_grant = -1;
        for (int k = 0; k < N_REQ; k++) begin
            int i = (p + k) % N_REQ;
            if (e_grant < 0 && req_valid[i]) e_grant = i;
        end
        if (allowed && e_grant >= 0) e_ready[e_grant] = 1'b1;
        e_rv = fq.size() > 0;
        e_y  = e_rv ? fq[0].y : 32'd0;
        e_id = e_rv ? IDW'(fq[0].id) : '0;
    endtask

    task automatic model_edge();
        bit allowed;
        item_t it;
        allowed = (inq.size() + fq.size()) < DEPTH;
        ecnt++;
        if (req_valid != '0 && !allowed) m_stall++;
        if (e_rv && resp_ready) fq.delete(0);
        while (inq.size() > 0 && inq[0].due == ecnt) begin
            fq.push_back(inq[0]);
            inq.delete(0);
        end
        if (e_ready != '0) begin
            it.due = ecnt + NSTAGE + 1;
            it.y   = itof(req_x[32*e_grant +: 32]);
            it.id  = e_grant;
            inq.push_back(it);
            p = (e_grant + 1) % N_REQ;
            m_issued++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        resp_ready = 1'b0;
        inq.delete();
        fq.delete();
        p = 0; m_issued = 0; m_stall = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = '1;
        #1;
        checks++;
        if ({cv_x, req_ready, resp_valid, resp_y, resp_id} !== '0) begin
            errors++;
            $display("FAIL reset_state: cv_x=%h ready=%b rv=%b y=%h id=%0d required all zero",
                     cv_x, req_ready, resp_valid, resp_y, resp_id);
        end
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [31:0] xs [2];
        logic [31:0] ys [2];
        int          first_rv;
        logic [31:0] got_y;
        logic [IDW-1:0] got_id;
        xs[0] = 32'd5;        ys[0] = 32'h40A00000;
        xs[1] = 32'hFFFFFFFF; ys[1] = 32'hBF800000;
        for (int t = 0; t < 2; t++) begin
            first_rv = -1; got_y = '0; got_id = '0;
            for (int j = 0; j < 8; j++) begin
                req_valid = (j == 0) ? 2'b01 : 2'b00;
                req_x[31:0] = xs[t];
                resp_ready = 1'b1;
                #1;
                model_expect(); checks++;
                if (req_ready !== e_ready || resp_valid !== e_rv || (e_rv && (resp_y !== e_y || resp_id !== e_id))) begin
                    errors++;
                    $display("FAIL single cyc%0d: ready=%b rv=%b y=%h id=%0d required ready=%b rv=%b y=%h id=%0d",
                             j, req_ready, resp_valid, resp_y, resp_id, e_ready, e_rv, e_y, e_id);
                end
                if (resp_valid && first_rv < 0) begin
                    first_rv = j; got_y = resp_y; got_id = resp_id;
                end
                model_edge();
                @(negedge clk);
            end
            checks++;
            if (first_rv != NSTAGE + 2) begin
                errors++;
                $display("FAIL single_latency: first resp cycle=%0d required %0d", first_rv, NSTAGE + 2);
            end
            checks++;
            if (got_y !== ys[t] || got_id !== 1'b0) begin
                errors++;
                $display("FAIL single_value: y=%h id=%0d required y=%h id=0", got_y, got_id, ys[t]);
            end
        end
    endtask

    task automatic test_alternate();
        int prev = -1, g, nresp = 0;
        logic [IDW-1:0] prev_id = '1;
        for (int j = 0; j < 20; j++) begin
            req_valid = (j < 12) ? 2'b11 : 2'b00;
            req_x = {32'd2, 32'd1};
            resp_ready = 1'b1;
            #1;
            model_expect(); checks++;
            if (req_ready !== e_ready || resp_valid !== e_rv || (e_rv && (resp_y !== e_y || resp_id !== e_id))) begin
                errors++;
                $display("FAIL alternate cyc%0d: ready=%b rv=%b y=%h id=%0d required ready=%b rv=%b y=%h id=%0d",
                         j, req_ready, resp_valid, resp_y, resp_id, e_ready, e_rv, e_y, e_id);
            end
            if (req_ready != '0) begin
                g = req_ready[1] ? 1 : 0;
                if (prev >= 0) begin
                    checks++;
                    if (g == prev) begin
                        errors++;
                        $display("FAIL alternate_grant: grant=%0d required %0d", g, 1 - prev);
                    end
                end
                prev = g;
            end
            if (resp_valid) begin
                checks++;
                if (resp_y !== (resp_id ? 32'h40000000 : 32'h3F800000) || (nresp > 0 && resp_id === prev_id)) begin
                    errors++;
                    $display("FAIL alternate_resp: y=%h id=%0d previous id=%0d", resp_y, resp_id, prev_id);
                end
                prev_id = resp_id;
                nresp++;
            end
            model_edge();
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        int k = 1, acc = 0, npop = 0;
        logic [31:0] popped [16];
        logic [31:0] exp4 [4];
        exp4[0] = 32'h3F800000; exp4[1] = 32'h40000000; exp4[2] = 32'h40400000; exp4[3] = 32'h40800000;
        do_reset();
        for (int j = 0; j < 45; j++) begin
            req_valid = (k <= 10) ? 2'b10 : 2'b00;
            req_x[63:32] = k;
            resp_ready = (j >= 12);
            #1;
            model_expect(); checks++;
            if (req_ready !== e_ready || resp_valid !== e_rv || (e_rv && (resp_y !== e_y || resp_id !== e_id))) begin
                errors++;
                $display("FAIL backpressure cyc%0d: ready=%b rv=%b y=%h id=%0d required ready=%b rv=%b y=%h id=%0d",
                         j, req_ready, resp_valid, resp_y, resp_id, e_ready, e_rv, e_y, e_id);
            end
            if (j == 12) begin
                checks++;
                if (acc != DEPTH || req_ready !== 2'b00) begin
                    errors++;
                    $display("FAIL backpressure_fill: accepts=%0d ready=%b required %0d and 00", acc, req_ready, DEPTH);
                end
            end
            if (resp_valid && resp_ready && npop < 16) begin
                popped[npop] = resp_y;
                npop++;
            end
            model_edge();
            if (req_valid[1] && req_ready[1]) begin
                k++; acc++;
            end
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (popped[i] !== exp4[i]) begin
                errors++;
                $display("FAIL backpressure_order[%0d]: y=%h required %h", i, popped[i], exp4[i]);
            end
        end
        checks++;
        if (npop != 10) begin
            errors++;
            $display("FAIL backpressure_count: pops=%0d required 10", npop);
        end
`ifdef ITOF_SCHED_PERF_EN
        checks++;
        if (perf_issued !== 32'd10 || perf_stall !== 32'(m_stall)) begin
            errors++;
            $display("FAIL perf: issued=%0d stall=%0d required 10 and %0d", perf_issued, perf_stall, m_stall);
        end
`endif
    endtask

    task automatic test_pulse();
        do_reset();
        for (int j = 0; j < 14; j++) begin
            req_valid = 2'b01;
            req_x[31:0] = $urandom;
            resp_ready = (j == 10);
            #1;
            model_expect(); checks++;
            if (req_ready !== e_ready || resp_valid !== e_rv || (e_rv && (resp_y !== e_y || resp_id !== e_id))) begin
                errors++;
                $display("FAIL pulse cyc%0d: ready=%b rv=%b y=%h id=%0d required ready=%b rv=%b y=%h id=%0d",
                         j, req_ready, resp_valid, resp_y, resp_id, e_ready, e_rv, e_y, e_id);
            end
            if (j == 10 || j == 11 || j == 12) begin
                checks++;
                if (req_ready !== ((j == 11) ? 2'b01 : 2'b00) || resp_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL pulse_credit cyc%0d: ready=%b rv=%b required ready=%b rv=1",
                             j, req_ready, resp_valid, (j == 11) ? 2'b01 : 2'b00);
                end
            end
            model_edge();
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int j = 0; j < 5; j++) begin
            req_valid = (j < 4) ? 2'b01 : 2'b00;
            req_x[31:0] = 32'(j + 7);
            #1;
            model_expect();
            model_edge();
            @(negedge clk);
        end
        checks++;
        if (resp_valid !== 1'b1 || inq.size() != 2 || fq.size() != 2) begin
            errors++;
            $display("FAIL reset_mid_setup: rv=%b inflight=%0d buffered=%0d required 1, 2, 2",
                     resp_valid, inq.size(), fq.size());
        end
        req_valid = 2'b11;
        rst = 1'b1;
        #1;
        checks++;
        if ({cv_x, req_ready, resp_valid, resp_y, resp_id} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: cv_x=%h ready=%b rv=%b y=%h id=%0d required all zero",
                     cv_x, req_ready, resp_valid, resp_y, resp_id);
        end
        do_reset();
        for (int j = 0; j < 14; j++) begin
            req_valid = (j == 8) ? 2'b10 : 2'b00;
            req_x[63:32] = 32'hFFFF_0000;
            resp_ready = 1'b1;
            #1;
            model_expect(); checks++;
            if (req_ready !== e_ready || resp_valid !== e_rv || (e_rv && (resp_y !== e_y || resp_id !== e_id))) begin
                errors++;
                $display("FAIL reset_mid_after cyc%0d: ready=%b rv=%b y=%h id=%0d required ready=%b rv=%b y=%h id=%0d",
                         j, req_ready, resp_valid, resp_y, resp_id, e_ready, e_rv, e_y, e_id);
            end
            model_edge();
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 400; j++) begin
            req_valid = (j < 380) ? N_REQ'($urandom) : '0;
            for (int i = 0; i < N_REQ; i++) begin
                req_x[32*i +: 32] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            #1;
            model_expect(); checks++;
            if (req_ready !== e_ready || resp_valid !== e_rv || (e_rv && (resp_y !== e_y || resp_id !== e_id))) begin
                errors++;
                $display("FAIL random cyc%0d: ready=%b rv=%b y=%h id=%0d required ready=%b rv=%b y=%h id=%0d",
                         j, req_ready, resp_valid, resp_y, resp_id, e_ready, e_rv, e_y, e_id);
            end
            model_edge();
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        test_single();
        test_alternate();
        test_backpressure();
        test_pulse();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
